// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks: default widths, buffer
// depth limits, the data word type and a circular pointer helper.
package fifo_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int SKID_MIN      = 2;
    localparam int SKID_MAX      = 8;

    typedef logic [WIDTH_DEFAULT-1:0] fifo_data_t;

    // Advance a circular pointer over n entries, wrapping from n-1 back to 0.
    function automatic int wrap_inc(input int ptr, input int n);
        return (ptr == n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// SKID-entry circular register buffer. Push writes at the tail, pop retires
// the head, flush empties it. The head word is visible combinationally so
// the stream side can present it without an extra register stage.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int SKID  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head_data,
    output logic [$clog2(SKID+1)-1:0] level,
    output logic                      full
);

    localparam int PW = $clog2(SKID);
    localparam int LW = $clog2(SKID + 1);

    logic [WIDTH-1:0] mem_reg [SKID];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;

    // Pointer and occupancy tracking; flush returns everything to the empty state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= PW'(wrap_inc(int'(wr_ptr_reg), SKID));
            end
            if (pop) begin
                rd_ptr_reg <= PW'(wrap_inc(int'(rd_ptr_reg), SKID));
            end
            if (push && !pop) begin
                level_reg <= level_reg + LW'(1);
            end else if (!push && pop) begin
                level_reg <= level_reg - LW'(1);
            end
        end
    end

    // Data storage; contents need no reset because level gates their visibility
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign level     = level_reg;
    assign full      = (level_reg == LW'(SKID));

endmodule

// File: rtl/fifo_rd_prefetch.sv
// Read-side output stage of the async FIFO. Issues FIFO reads only when a
// buffer slot is guaranteed for the returning word (buffered + in-flight
// accounting), presents the buffer head as a valid/ready stream and flags
// any return that finds the buffer full.
module fifo_rd_prefetch
    import fifo_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int SKID   = 2,
    parameter int RD_LAT = 1
) (
    input  logic                      rclk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    output logic                      fifo_rd_en_o,
    input  logic [WIDTH-1:0]          fifo_rdata_i,
    input  logic                      fifo_empty_i,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [WIDTH-1:0]          m_data_o,
    output logic [$clog2(SKID+1)-1:0] level_o,
    output logic                      error_o
);

    localparam int LW = $clog2(SKID + 1);
    localparam int CW = LW + 1;

    logic             pop;
    logic             push;
    logic             ret_valid;
    logic             inflight;
    logic             full;
    logic             overrun;
    logic             error_reg;
    logic [CW-1:0]    committed;
    logic [LW-1:0]    level;
    logic [WIDTH-1:0] head_data;

    assign m_valid_o = (level != '0);
    assign pop       = m_valid_o && m_ready_i;

    // Slots already promised: buffered words plus reads still in flight, less
    // the word leaving this cycle.
    assign committed = {1'b0, level} + CW'(inflight) - CW'(pop);

    // The strobe is also held low while reset is asserted so the FIFO is never
    // read on behalf of a block that is about to lose the data.
    assign fifo_rd_en_o = rst_i && !fifo_empty_i && !flush_i && (committed < CW'(SKID));

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign inflight  = 1'b0;
            assign ret_valid = fifo_rd_en_o;
        end else begin : g_lat1
            logic inflight_reg;

            // Track the single outstanding read; flush suppresses the strobe, so it also clears this
            always_ff @(posedge rclk_i or negedge rst_i) begin
                if (!rst_i) begin
                    inflight_reg <= 1'b0;
                end else begin
                    inflight_reg <= fifo_rd_en_o;
                end
            end

            assign inflight  = inflight_reg;
            assign ret_valid = inflight_reg;
        end
    endgenerate

    // A return during flush belongs to a pre-flush read and is dropped; a return
    // into a full buffer with no pop is a credit fault and is dropped as well.
    assign overrun = ret_valid && !flush_i && full && !pop;
    assign push    = ret_valid && !flush_i && !overrun;

    fifo_skid_buf #(
        .WIDTH (WIDTH),
        .SKID  (SKID)
    ) u_buf (
        .clk       (rclk_i),
        .rst_n     (rst_i),
        .flush     (flush_i),
        .push      (push),
        .push_data (fifo_rdata_i),
        .pop       (pop),
        .head_data (head_data),
        .level     (level),
        .full      (full)
    );

    // Sticky overrun flag; flush leaves it alone, only reset clears it
    always_ff @(posedge rclk_i or negedge rst_i) begin
        if (!rst_i) begin
            error_reg <= 1'b0;
        end else if (overrun) begin
            error_reg <= 1'b1;
        end
    end

    assign m_data_o = m_valid_o ? head_data : '0;
    assign level_o  = level;
    assign error_o  = error_reg;

endmodule
